// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared ALU definitions, also used by the ALU decoder.
//   ALU_CTRL_W  : width of the alu_control code
//   alu_op_e    : the five legal operation codes
//   alu_flags_t : status flags that travel with a result
//   alu_bundle_t: result plus flags at the default datapath width
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_CTRL_W = 3;
  localparam int ALU_DATA_W = 32;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    alu_flags_t            flags;
  } alu_bundle_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_if
// Handshake and data signals of the execute stage.
//   in_valid/in_ready            : upstream handshake
//   alu_control, src_a, src_b    : operation and operands
//   out_valid/out_ready          : downstream handshake
//   result, zero, overflow, illegal : output bundle
// master: the surrounding pipeline (drives ops, drives out_ready)
// slave : the execute stage itself
// -----------------------------------------------------------------------------
interface alu_exec_stage_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [WIDTH-1:0]      src_a;
  logic [WIDTH-1:0]      src_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      result;
  logic                  zero;
  logic                  overflow;
  logic                  illegal;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU: operation code + operands -> result and flags.
//   ctrl_i   : alu_control code
//   a_i, b_i : two's complement operands
//   result_o : operation result (0 for illegal codes)
//   flags_o  : zero / overflow / illegal
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_CTRL_W-1:0] ctrl_i,
  input  logic [WIDTH-1:0]      a_i,
  input  logic [WIDTH-1:0]      b_i,
  output logic [WIDTH-1:0]      result_o,
  output alu_flags_t            flags_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             a_msb;
  logic             b_msb;

  assign sum   = a_i + b_i;
  assign diff  = a_i - b_i;
  assign a_msb = a_i[WIDTH-1];
  assign b_msb = b_i[WIDTH-1];

  always_comb begin
    result_o = '0;
    flags_o  = '0;
    // Any code outside the five legal ones (including X in simulation)
    // lands in the default branch and is flagged illegal.
    case (ctrl_i)
      ALU_ADD: begin
        result_o         = sum;
        flags_o.overflow = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      end
      ALU_SUB: begin
        result_o         = diff;
        flags_o.overflow = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      // True signed compare, not the sign of a-b, so it stays correct
      // when the subtraction would overflow.
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: flags_o.illegal = 1'b1;
    endcase
    flags_o.zero = !flags_o.illegal && (result_o == '0);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// One-cycle registered execute stage with valid/ready flow control and a
// one-entry skid buffer, so in_ready is a pure flop output.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_exec_stage_if slave (handshakes, operands, result bundle)
// -----------------------------------------------------------------------------
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_stage_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
  } bundle_t;

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  bundle_t          new_bundle;

  bundle_t out_q,  out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q,  out_valid_d;
  logic    skid_valid_q, skid_valid_d;

  logic accept;
  logic out_free;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .ctrl_i   (bus.alu_control),
    .a_i      (bus.src_a),
    .b_i      (bus.src_b),
    .result_o (core_result),
    .flags_o  (core_flags)
  );

  assign new_bundle = '{result: core_result, flags: core_flags};

  // in_ready depends only on the skid flop, never on out_ready.
  assign accept   = bus.in_valid && !skid_valid_q;
  assign out_free = !out_valid_q || bus.out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        // Older op in the skid buffer goes first to keep FIFO order.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = new_bundle;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = new_bundle;
      end
    end else if (accept) begin
      // OUT is stalled: park the new op until OUT drains.
      skid_d       = new_bundle;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = out_q.result;
  assign bus.zero      = out_q.flags.zero;
  assign bus.overflow  = out_q.flags.overflow;
  assign bus.illegal   = out_q.flags.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
// Scoreboard bench: the driver pushes the expected bundle when an op is
// accepted, an independent monitor pops and compares on every emit.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_stage_if #(.WIDTH(32)) bus ();

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        i;
  } exp_t;

  exp_t q[$];
  int   emit_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   txn = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on sign-extended operands.
  function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.c = c; e.a = a; e.b = b; e.res = '0; e.o = 1'b0; e.i = 1'b0;
    case (c)
      3'b010: begin r = sa + sb; e.res = r[31:0]; e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'b110: begin r = sa - sb; e.res = r[31:0]; e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.i = 1'b1;
    endcase
    e.z = !e.i && (e.res == 32'd0);
    return e;
  endfunction

  function automatic exp_t mk(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic z, input logic o, input logic i);
    exp_t e;
    e.c = c; e.a = a; e.b = b; e.res = res; e.z = z; e.o = o; e.i = i;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input exp_t e);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    bus.in_valid    = 1'b1;
    bus.alu_control = e.c;
    bus.src_a       = e.a;
    bus.src_b       = e.b;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        done = 1;
      end else if (++n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        done = 1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d ops still pending, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
    chk("drained_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every emit, checks order/value and stall stability.
  initial begin : monitor
    logic [34:0] held;
    bit          held_v;
    exp_t        e;
    held_v = 0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 0;
      end else begin
        if (held_v)
          chk("stall_stable", 64'({bus.result, bus.zero, bus.overflow, bus.illegal}), 64'(held));
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got result 0x%08h, required no output", bus.result);
          end else begin
            e = q.pop_front();
            txn++;
            emit_cyc.push_back(cyc);
            $display("txn %0d ctrl=%b a=%08h b=%08h result=%08h z=%0b ov=%0b ill=%0b",
                     txn, e.c, e.a, e.b, bus.result, bus.zero, bus.overflow, bus.illegal);
            chk("result", 64'(bus.result), 64'(e.res));
            chk("flags", 64'({bus.zero, bus.overflow, bus.illegal}), 64'({e.z, e.o, e.i}));
          end
        end
        held_v = bus.out_valid && !bus.out_ready;
        held   = {bus.result, bus.zero, bus.overflow, bus.illegal};
      end
    end
  end

  initial begin : driver
    int   c0;
    bit   have;
    int   sent;
    int   guard;
    exp_t cur;
    logic [31:0] sp [6];
    sp = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};

    bus.in_valid = 1'b0; bus.alu_control = '0; bus.src_a = '0; bus.src_b = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_result", 64'(bus.result), 64'd0);
    chk("reset_flags", 64'({bus.zero, bus.overflow, bus.illegal}), 64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // Continuous stream, one op per cycle.
    c0 = cyc;
    send(mk(3'b010, 32'd7, 32'd5, 32'd12, 0, 0, 0));
    send(mk(3'b110, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0));
    send(mk(3'b000, 32'hF0, 32'h3C, 32'h30, 0, 0, 0));
    send(mk(3'b001, 32'hF0, 32'h0F, 32'hFF, 0, 0, 0));
    send(mk(3'b111, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0));
    chk("stream_cycles", 64'(cyc - c0), 64'd5);
    drain();

    // Single-op latency: visible right after the accepting edge, then gone.
    send(mk(3'b000, 32'hF0, 32'h3C, 32'h30, 0, 0, 0));
    @(negedge clk);
    chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    chk("no_duplicate", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;

    // Overflow / compare edges and illegal codes in between legal ops.
    send(mk(3'b010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 1, 0));
    send(mk(3'b110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1, 0));
    send(mk(3'b111, 32'h80000000, 32'h7FFFFFFF, 32'd1, 0, 0, 0));
    send(mk(3'b111, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1, 0, 0));
    send(mk(3'b110, 32'd9, 32'd9, 32'd0, 1, 0, 0));
    send(mk(3'b010, 32'd1, 32'd1, 32'd2, 0, 0, 0));
    send(mk(3'b011, 32'd0, 32'd0, 32'd0, 0, 0, 1));
    send(mk(3'b100, 32'd5, 32'd6, 32'd0, 0, 0, 1));
    send(mk(3'b101, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 1));
    send(mk(3'b001, 32'd1, 32'd2, 32'd3, 0, 0, 0));
    drain();

    // Back-pressure: two accepted, third blocked, then FIFO release.
    bus.out_ready = 1'b0;
    send(mk(3'b001, 32'd1, 32'd2, 32'd3, 0, 0, 0));
    send(mk(3'b000, 32'hFF, 32'h0F, 32'h0F, 0, 0, 0));
    bus.in_valid = 1'b1; bus.alu_control = 3'b110; bus.src_a = 32'd10; bus.src_b = 32'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_holds_op1", 64'(bus.result), 64'd3);
      @(posedge clk); #1;
    end
    emit_cyc.delete();
    bus.out_ready = 1'b1;
    send(mk(3'b110, 32'd10, 32'd3, 32'd7, 0, 0, 0));
    @(negedge clk);
    chk("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    drain();
    chk("bp_emit_count", 64'(emit_cyc.size()), 64'd3);
    if (emit_cyc.size() == 3) begin
      chk("bp_consecutive_1", 64'(emit_cyc[1] - emit_cyc[0]), 64'd1);
      chk("bp_consecutive_2", 64'(emit_cyc[2] - emit_cyc[1]), 64'd1);
    end

    // Random traffic on both handshakes.
    have = 0; sent = 0; guard = 0;
    while (sent < 10000 && guard < 60000) begin
      guard++;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!have && $urandom_range(0, 3) != 0) begin
        cur = model(3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom,
                    ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom);
        have = 1;
      end
      bus.in_valid = have;
      if (have) begin
        bus.alu_control = cur.c; bus.src_a = cur.a; bus.src_b = cur.b;
      end
      @(negedge clk);
      if (have && bus.in_ready) begin
        q.push_back(cur);
        have = 0;
        sent++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("random_ops_issued", 64'(sent), 64'd10000);
    drain();

    // Reset while OUT and SKID are both full.
    bus.out_ready = 1'b0;
    send(mk(3'b010, 32'd1, 32'd2, 32'd3, 0, 0, 0));
    send(mk(3'b010, 32'd3, 32'd4, 32'd7, 0, 0, 0));
    @(negedge clk);
    chk("pre_reset_in_ready", 64'(bus.in_ready), 64'd0);
    chk("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("async_reset_result", 64'(bus.result), 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_no_stale", 64'(bus.out_valid), 64'd0);
    end
    chk("post_reset_result", 64'(bus.result), 64'd0);
    @(posedge clk); #1;
    send(mk(3'b001, 32'd5, 32'd8, 32'd13, 0, 0, 0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered, flow-controlled execute stage that consumes the 3-bit `alu_control` code produced by the ALU decoder and performs the selected operation on two operands. It sits between the decode/operand-fetch logic and writeback/branch logic. It provides a one-cycle-latency valid/ready pipeline slot with a one-entry skid buffer, so back-pressure from downstream never drops or duplicates an operation. It also flags signed overflow and illegal control codes.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥ 2)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  stage can accept this cycle
- `alu_control`  in  3  operation code (010 add, 110 sub, 000 and, 001 or, 111 slt)
- `src_a`, `src_b`  in  WIDTH  operands (two's complement)
- `out_valid`  out  1  result presented
- `out_ready`  in  1  downstream accepts
- `result`  out  WIDTH  operation result
- `zero`  out  1  `result == 0` (branch compare)
- `overflow`  out  1  signed overflow on add/sub
- `illegal`  out  1  `alu_control` was 011, 100, 101 or X

## Operation
- Add: `result = a + b`, mod 2^WIDTH. Overflow when the operand signs match and the result sign differs.
- Sub: `result = a - b`, mod 2^WIDTH. Overflow when the operand signs differ and the result sign differs from `a`.
- And/Or: bitwise. Overflow is 0.
- SLT: `result = {0…, (a <s b)}` using a true signed compare, correct even where `a - b` overflows. Overflow is 0.
- Illegal code: `result = 0`, `zero = 0`, `overflow = 0`, `illegal = 1`. The operation is still passed through the pipeline, not dropped.
- Flags are computed with the result and travel with it as one bundle.
- Storage:
  - Output register (OUT) drives the outputs.
  - Skid register (SKID) holds one bundle while OUT is stalled.
- `in_ready = !skid_valid`, driven straight from a flop with no combinational path from `out_ready`.

## Timing
- Reset (async assert, sync deassert is handled externally):
  - `out_valid = 0`, `in_ready = 1`
  - `result = 0`, `zero = 0`, `overflow = 0`, `illegal = 0`
  - SKID is empty
- Accept happens on a rising edge with `in_valid && in_ready`. Emit happens on a rising edge with `out_valid && out_ready`.
- Latency: an op accepted at edge N is visible on the outputs after edge N when OUT is free or emitting at N.
- Throughput: 1 op/cycle while `out_ready` stays high.
- Per-edge rules:
  - OUT empty or emitting: OUT ← SKID if SKID is valid, else the new accept. If both exist, OUT ← SKID and SKID ← new accept.
  - OUT full and not emitting: a new accept goes to SKID. `in_ready` falls on the next cycle.
  - SKID full: no accept is possible (`in_ready = 0`). SKID drains into OUT on the next emit and `in_ready` rises on the following cycle.
- Output bundle is stable while `out_valid && !out_ready`.
- Order is strictly FIFO. No op is lost or duplicated.
- Reset mid-operation discards both OUT and SKID immediately.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum with the five legal codes
  - bundle struct {result, zero, overflow, illegal}
  - the `ALU_CTRL_W = 3` constant
  - shared with the ALU decoder
- Sub-module `alu_core`: purely combinational op→bundle function, instantiated once on the input side.
- Top level holds only the OUT/SKID registers and the valid/ready logic.

## Test plan
- Reset, then a continuous stream with `out_ready = 1`: add 7+5, sub 5−7, and 0xF0&0x3C, or 0xF0|0x0F, slt −1<1. Expect the outputs 1 cycle later: 12, 0xFFFFFFFE, 0x30, 0xFF, 1. `zero = 0` throughout. One op per cycle.
- Overflow and compare edge cases:
  - add 0x7FFFFFFF+1 → 0x80000000, overflow 1
  - sub 0x80000000−1 → overflow 1
  - slt 0x80000000<0x7FFFFFFF → 1
  - sub 9−9 → 0, zero 1
- Illegal codes 011, 100, 101 → result 0, illegal 1, zero 0. The ops before and after complete normally and in order.
- Back-pressure: hold `out_ready = 0` while issuing 3 ops.
  - Expect 2 accepted, then `in_ready = 0`. The output holds op 1 stable.
  - Raise `out_ready`: ops 1, 2, 3 emerge in order on consecutive cycles. `in_ready` returns to 1.
- Random `in_valid`/`out_ready` over 10k ops against a scoreboard: no loss, no duplication, in order.
- Assert `rst_n` low while OUT and SKID are both full. Expect `out_valid = 0`, `in_ready = 1` asynchronously, and no stale result after release.
